// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: shared types and constants for the UART AXI bridge.
//   uart_state_e     : bridge transaction FSM states
//   UART_DATA_OFF    : addr[3:2] of the DATA register (byte offset 0x8)
//   UART_STAT_OFF    : addr[3:2] of the STATUS register (byte offset 0xC)
//   RESP_OKAY/SLVERR : AXI response codes
//   reg_resp()       : AXI response for an addr[3:2] register selector
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    R_RESP = 3'd1,
    W_DATA = 3'd2,
    W_TX   = 3'd3,
    B_RESP = 3'd4
  } uart_state_e;

  localparam logic [1:0] UART_DATA_OFF = 2'b10;
  localparam logic [1:0] UART_STAT_OFF = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] reg_resp(input logic [1:0] off);
    return ((off == UART_DATA_OFF) || (off == UART_STAT_OFF)) ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous receive-byte FIFO with asynchronous active-high reset.
//   clk_i, rst_i : clock, async active-high reset
//   push_i       : write data_i (honoured when not full, or when a pop happens
//                  in the same cycle, so a full FIFO can swap one entry)
//   pop_i        : drop the head entry (ignored when empty)
//   data_i       : byte to push
//   head_o       : oldest entry, valid while empty_o is low
//   full_o       : no room for a push without a simultaneous pop
//   empty_o      : no entries held
// DEPTH must be a power of two; DEPTH == 1 builds a single holding register.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  logic do_push;
  logic do_pop;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  if (DEPTH == 1) begin : g_hold
    logic [W-1:0] data_q;
    logic         valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (do_push) begin
        // A push with a simultaneous pop replaces the entry in place.
        data_q  <= data_i;
        valid_q <= 1'b1;
      end else if (do_pop) begin
        valid_q <= 1'b0;
      end
    end

    assign head_o  = data_q;
    assign full_o  = valid_q;
    assign empty_o = !valid_q;
  end else begin : g_ring
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;

    // Storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
      end
    end

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (do_push) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
          cnt_q <= cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
  end

endmodule

// File: rtl/uart_axi_bridge.sv
// uart_axi_bridge: AXI4 slave exposing a two-register UART (DATA at 0x8,
// STATUS at 0xC) over a byte transmitter / receiver pair, with buffered RX.
//   clk, rst               : system clock, async active-high reset
//   io_uart_ar_* / r_*     : AXI read address / read data channels (single beat)
//   io_uart_aw_* / w_* / b_*: AXI write address / data / response channels
//   tx_start, tx_data      : one-cycle transmit request and its byte
//   tx_busy                : transmitter busy
//   rx_ready, rx_data      : receiver holds a byte
//   rx_clear               : one-cycle pulse releasing the receiver's byte
//   dbg_state_o            : current FSM state, for observation
// Configuration macro UART_RX_FIFO_EN: when defined the RX buffer holds
// RX_FIFO_DEPTH bytes; otherwise a single-byte holding register is used.
//
// Handshake rule for every AXI channel: a transfer happens on a rising edge
// where both valid and ready are high; valid is held with stable payload
// until that edge.
module uart_axi_bridge
  import uart_bridge_pkg::*;
#(
  parameter int RX_FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_uart_ar_id,
  input  logic [31:0] io_uart_ar_addr,
  input  logic [7:0]  io_uart_ar_len,
  input  logic [2:0]  io_uart_ar_size,
  input  logic [1:0]  io_uart_ar_burst,
  input  logic        io_uart_ar_valid,
  output logic        io_uart_ar_ready,
  output logic [7:0]  io_uart_r_id,
  output logic [1:0]  io_uart_r_resp,
  output logic [31:0] io_uart_r_data,
  output logic        io_uart_r_last,
  output logic        io_uart_r_valid,
  input  logic        io_uart_r_ready,
  input  logic [7:0]  io_uart_aw_id,
  input  logic [31:0] io_uart_aw_addr,
  input  logic [7:0]  io_uart_aw_len,
  input  logic [2:0]  io_uart_aw_size,
  input  logic [1:0]  io_uart_aw_burst,
  input  logic        io_uart_aw_valid,
  output logic        io_uart_aw_ready,
  input  logic [31:0] io_uart_w_data,
  input  logic [3:0]  io_uart_w_strb,
  input  logic        io_uart_w_last,
  input  logic        io_uart_w_valid,
  output logic        io_uart_w_ready,
  output logic [7:0]  io_uart_b_id,
  output logic [1:0]  io_uart_b_resp,
  output logic        io_uart_b_valid,
  input  logic        io_uart_b_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        rx_clear,
  output logic [2:0]  dbg_state_o
);

`ifdef UART_RX_FIFO_EN
  localparam int FIFO_DEPTH = RX_FIFO_DEPTH;
`else
  localparam int FIFO_DEPTH = 1;
`endif

  uart_state_e state_q, state_d;
  logic [7:0]  r_id_q, r_id_d;
  logic [1:0]  r_resp_q, r_resp_d;
  logic [31:0] r_data_q, r_data_d;
  logic [7:0]  b_id_q, b_id_d;
  logic [1:0]  b_resp_q, b_resp_d;
  logic [1:0]  wsel_q, wsel_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic       rx_pop;
  logic       rx_push;
  logic       rx_full;
  logic       rx_empty;
  logic [7:0] rx_head;
  logic       tx_idle;

  // Burst/size fields and the unused address bits are accepted but ignored.
  logic unused_ok;
  assign unused_ok = ^{io_uart_ar_addr[31:4], io_uart_ar_addr[1:0], io_uart_ar_len,
                       io_uart_ar_size, io_uart_ar_burst, io_uart_aw_addr[31:4],
                       io_uart_aw_addr[1:0], io_uart_aw_len, io_uart_aw_size,
                       io_uart_aw_burst, io_uart_w_data[31:8], io_uart_w_strb[3:1],
                       io_uart_w_last};

  assign tx_idle = !tx_busy && (state_q != W_TX);

  // The receiver is released in the same cycle its byte is buffered. A full
  // buffer still accepts when a DATA read frees the head in that cycle.
  // Held off during reset so no byte is released into a buffer being cleared.
  assign rx_push  = rx_ready && !rst && (!rx_full || rx_pop);
  assign rx_clear = rx_push;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_rx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .data_i  (rx_data),
    .head_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      r_id_q    <= '0;
      r_resp_q  <= '0;
      r_data_q  <= '0;
      b_id_q    <= '0;
      b_resp_q  <= '0;
      wsel_q    <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      r_id_q    <= r_id_d;
      r_resp_q  <= r_resp_d;
      r_data_q  <= r_data_d;
      b_id_q    <= b_id_d;
      b_resp_q  <= b_resp_d;
      wsel_q    <= wsel_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    r_id_d    = r_id_q;
    r_resp_d  = r_resp_q;
    r_data_d  = r_data_q;
    b_id_d    = b_id_q;
    b_resp_d  = b_resp_q;
    wsel_d    = wsel_q;
    tx_data_d = tx_data_q;
    rx_pop    = 1'b0;
    tx_start  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Reads win over writes; the read response is fully captured here so
        // r_data stays stable for the whole R_RESP phase.
        if (io_uart_ar_valid) begin
          state_d  = R_RESP;
          r_id_d   = io_uart_ar_id;
          r_resp_d = reg_resp(io_uart_ar_addr[3:2]);
          r_data_d = '0;
          if (io_uart_ar_addr[3:2] == UART_DATA_OFF) begin
            if (!rx_empty) begin
              r_data_d = {24'b0, rx_head};
              rx_pop   = 1'b1;
            end
          end else if (io_uart_ar_addr[3:2] == UART_STAT_OFF) begin
            r_data_d = {30'b0, !rx_empty, tx_idle};
          end
        end else if (io_uart_aw_valid) begin
          state_d  = W_DATA;
          b_id_d   = io_uart_aw_id;
          b_resp_d = reg_resp(io_uart_aw_addr[3:2]);
          wsel_d   = io_uart_aw_addr[3:2];
        end
      end
      R_RESP: begin
        if (io_uart_r_ready) begin
          state_d = IDLE;
        end
      end
      W_DATA: begin
        if (io_uart_w_valid) begin
          if ((wsel_q == UART_DATA_OFF) && io_uart_w_strb[0]) begin
            state_d   = W_TX;
            tx_data_d = io_uart_w_data[7:0];
          end else begin
            state_d = B_RESP;
          end
        end
      end
      W_TX: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = B_RESP;
        end
      end
      B_RESP: begin
        if (io_uart_b_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io_uart_ar_ready = (state_q == IDLE);
  assign io_uart_aw_ready = (state_q == IDLE) && !io_uart_ar_valid;
  assign io_uart_w_ready  = (state_q == W_DATA);
  assign io_uart_r_valid  = (state_q == R_RESP);
  assign io_uart_r_id     = r_id_q;
  assign io_uart_r_resp   = r_resp_q;
  assign io_uart_r_data   = r_data_q;
  assign io_uart_r_last   = 1'b1;
  assign io_uart_b_valid  = (state_q == B_RESP);
  assign io_uart_b_id     = b_id_q;
  assign io_uart_b_resp   = b_resp_q;
  assign tx_data          = tx_data_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_uart_axi_bridge.sv
// tb_uart_axi_bridge: directed bench for uart_axi_bridge. A queue-based model
// of the UART register map and RX buffer predicts every response; one compare
// process checks the DUT on each falling edge, and the directed tests pin the
// model with hand-computed literals.
module tb_uart_axi_bridge;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 16;
`else
  localparam int DEPTH = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [7:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        ar_valid;
  logic        ar_ready;
  logic [7:0]  r_id;
  logic [1:0]  r_resp;
  logic [31:0] r_data;
  logic        r_last;
  logic        r_valid;
  logic        r_ready;
  logic [7:0]  aw_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic        w_valid;
  logic        w_ready;
  logic [7:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_clear;
  logic [2:0]  dbg_state;

  uart_axi_bridge #(.RX_FIFO_DEPTH(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .io_uart_ar_id    (ar_id),
    .io_uart_ar_addr  (ar_addr),
    .io_uart_ar_len   (ar_len),
    .io_uart_ar_size  (ar_size),
    .io_uart_ar_burst (ar_burst),
    .io_uart_ar_valid (ar_valid),
    .io_uart_ar_ready (ar_ready),
    .io_uart_r_id     (r_id),
    .io_uart_r_resp   (r_resp),
    .io_uart_r_data   (r_data),
    .io_uart_r_last   (r_last),
    .io_uart_r_valid  (r_valid),
    .io_uart_r_ready  (r_ready),
    .io_uart_aw_id    (aw_id),
    .io_uart_aw_addr  (aw_addr),
    .io_uart_aw_len   (aw_len),
    .io_uart_aw_size  (aw_size),
    .io_uart_aw_burst (aw_burst),
    .io_uart_aw_valid (aw_valid),
    .io_uart_aw_ready (aw_ready),
    .io_uart_w_data   (w_data),
    .io_uart_w_strb   (w_strb),
    .io_uart_w_last   (w_last),
    .io_uart_w_valid  (w_valid),
    .io_uart_w_ready  (w_ready),
    .io_uart_b_id     (b_id),
    .io_uart_b_resp   (b_resp),
    .io_uart_b_valid  (b_valid),
    .io_uart_b_ready  (b_ready),
    .tx_start         (tx_start),
    .tx_data          (tx_data),
    .tx_busy          (tx_busy),
    .rx_ready         (rx_ready),
    .rx_data          (rx_data),
    .rx_clear         (rx_clear),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model state ----------------
  logic [7:0]  mdl_q[$];       // bytes the bridge must be buffering, oldest first
  logic [41:0] exp_r_q[$];     // {id, resp, data} of outstanding read responses
  logic [9:0]  exp_b_q[$];     // {id, resp} of outstanding write responses
  logic [7:0]  exp_tx_q[$];    // bytes the bridge still owes the transmitter
  logic        tx_pending = 1'b0;
  int          w_cyc = 0;
  int          r_due = -1;
  int          b_due = -1;
  logic [1:0]  aw_off = 2'b00;
  logic [7:0]  aw_id_s = 8'h00;
  int          ar_hs_cyc = 0;
  int          aw_hs_cyc = 0;
  int          r_hs_cyc = 0;
  int          tx_cnt = 0;
  logic [7:0]  last_tx = 8'h00;

  // Receiver model: bytes queued in src_q are offered one at a time; a byte
  // is consumed once the bridge pulses rx_clear for it.
  logic [7:0] src_q[$];
  int         rx_taken = 0;
  int         rx_done = 0;

  always @(posedge clk) begin
    #1;
    if (rx_done < rx_taken) rx_done++;
    if (rx_done < src_q.size()) begin
      rx_ready = 1'b1;
      rx_data  = src_q[rx_done];
    end else begin
      rx_ready = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    logic [31:0] ed;
    logic [1:0]  er;
    logic        popped;
    int          room_pre;
    if (rst) begin
      mdl_q.delete();
      exp_r_q.delete();
      exp_b_q.delete();
      exp_tx_q.delete();
      tx_pending = 1'b0;
      r_due = -1;
      b_due = -1;
    end else begin
      popped = 1'b0;
      if (ar_valid) chk("aw_ready_yields_to_ar", aw_ready, 0);

      // Read address accepted: predict the response from the register map.
      if (ar_valid && ar_ready) begin
        ed = 32'h0;
        er = 2'b00;
        if (ar_addr[3:2] == 2'b10) begin
          if (mdl_q.size() > 0) begin
            ed = {24'h0, mdl_q.pop_front()};
            popped = 1'b1;
          end
        end else if (ar_addr[3:2] == 2'b11) begin
          ed = {30'h0, mdl_q.size() > 0, !tx_busy && !tx_pending};
        end else begin
          er = 2'b10;
        end
        exp_r_q.push_back({ar_id, er, ed});
        r_due = cyc + 1;
        ar_hs_cyc = cyc;
      end

      if (aw_valid && aw_ready) begin
        aw_off = aw_addr[3:2];
        aw_id_s = aw_id;
        aw_hs_cyc = cyc;
      end

      if (w_valid && w_ready) begin
        if (aw_off == 2'b10 && w_strb[0]) begin
          exp_tx_q.push_back(w_data[7:0]);
          tx_pending = 1'b1;
          w_cyc = cyc;
        end else begin
          exp_b_q.push_back({aw_id_s, (aw_off == 2'b10 || aw_off == 2'b11) ? 2'b00 : 2'b10});
          b_due = cyc + 1;
        end
      end

      // Transmitter requests: only owed bytes, only when idle, and no later
      // than the first idle cycle after the write data arrived.
      if (tx_start) begin
        chk("tx_start_while_busy", tx_busy, 0);
        if (exp_tx_q.size() == 0) chk("tx_start_unexpected", 1, 0);
        else chk("tx_data", tx_data, exp_tx_q.pop_front());
        tx_cnt++;
        last_tx = tx_data;
        tx_pending = 1'b0;
        exp_b_q.push_back({aw_id_s, 2'b00});
        b_due = cyc + 1;
      end else if (tx_pending && cyc > w_cyc && !tx_busy) begin
        chk("tx_start_late", 0, 1);
      end

      if (r_valid) begin
        if (exp_r_q.size() == 0) chk("r_valid_unexpected", 1, 0);
        else begin
          chk("r_data", r_data, exp_r_q[0][31:0]);
          chk("r_resp", r_resp, exp_r_q[0][33:32]);
          chk("r_id", r_id, exp_r_q[0][41:34]);
          chk("r_last", r_last, 1);
          if (r_ready) begin
            void'(exp_r_q.pop_front());
            r_hs_cyc = cyc;
          end
        end
      end
      if (cyc == r_due) begin
        chk("r_valid_latency", r_valid, 1);
        r_due = -1;
      end

      if (b_valid) begin
        if (exp_b_q.size() == 0) chk("b_valid_unexpected", 1, 0);
        else begin
          chk("b_resp", b_resp, exp_b_q[0][1:0]);
          chk("b_id", b_id, exp_b_q[0][9:2]);
          if (b_ready) void'(exp_b_q.pop_front());
        end
      end
      if (cyc == b_due) begin
        chk("b_valid_latency", b_valid, 1);
        b_due = -1;
      end

      // RX buffering: accept whenever there was room, never beyond capacity.
      if (rx_ready || rx_clear) begin
        room_pre = DEPTH - (mdl_q.size() + (popped ? 1 : 0));
        if (!rx_ready) chk("rx_clear_without_byte", rx_clear, 0);
        else if (room_pre > 0) chk("rx_clear", rx_clear, 1);
        else if (!popped) chk("rx_clear_when_full", rx_clear, 0);
        if (rx_ready && rx_clear) begin
          mdl_q.push_back(rx_data);
          rx_taken++;
          chk("rx_model_capacity", mdl_q.size() <= DEPTH, 1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] id, input int r_delay,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    ar_addr = addr;
    ar_id = id;
    ar_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ar_ready) break;
    end
    if (n >= 200) chk("ar_handshake_timeout", 0, 1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    repeat (r_delay) begin
      @(posedge clk); #1;
    end
    r_ready = 1'b1;
    data = 32'hDEAD_BEEF;
    resp = 2'b11;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (r_valid) break;
    end
    if (n >= 200) chk("r_timeout", 0, 1);
    else begin
      data = r_data;
      resp = r_resp;
    end
    @(posedge clk); #1;
    r_ready = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] id, input logic [31:0] data,
                           input logic [3:0] strb, input int b_delay, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    aw_addr = addr;
    aw_id = id;
    aw_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (aw_ready) break;
    end
    if (n >= 200) chk("aw_handshake_timeout", 0, 1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    w_data = data;
    w_strb = strb;
    w_valid = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (w_ready) break;
    end
    if (n >= 200) chk("w_handshake_timeout", 0, 1);
    @(posedge clk); #1;
    w_valid = 1'b0;
    repeat (b_delay) begin
      @(posedge clk); #1;
    end
    b_ready = 1'b1;
    resp = 2'b11;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (b_valid) break;
    end
    if (n >= 200) chk("b_timeout", 0, 1);
    else resp = b_resp;
    @(posedge clk); #1;
    b_ready = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- directed tests ----------------
  localparam logic [31:0] A_DATA = 32'hBFD0_03F8;
  localparam logic [31:0] A_STAT = 32'hBFD0_03FC;
  localparam logic [31:0] A_BAD0 = 32'hBFD0_03F0;
  localparam logic [31:0] A_BAD4 = 32'hBFD0_03F4;

  initial begin : stim
    logic [31:0] d;
    logic [1:0]  rs;
    int          base;
    int          tx0;
    ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 3'd2; ar_burst = 2'd1; ar_valid = 0;
    r_ready = 0;
    aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 3'd2; aw_burst = 2'd1; aw_valid = 0;
    w_data = 0; w_strb = 0; w_last = 1; w_valid = 0; b_ready = 0;
    tx_busy = 0;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_ar_ready", ar_ready, 1);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_rx_clear", rx_clear, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_ids", {r_id, b_id}, 0);
    chk("rst_resps", {r_resp, b_resp}, 0);
    chk("rst_state_idle", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // STATUS after reset: tx idle, nothing received
    axi_read(A_STAT, 8'h5A, 0, d, rs);
    chk("t1_status", d, 32'h1);
    chk("t1_resp", rs, 2'b00);

    // DATA read with empty buffer
    axi_read(A_DATA, 8'h01, 2, d, rs);
    chk("empty_data_read", d, 32'h0);
    chk("empty_data_resp", rs, 2'b00);

    // Write 0x41 while the transmitter is busy for 5 cycles
    tx0 = tx_cnt;
    tx_busy = 1'b1;
    fork
      axi_write(A_DATA, 8'h33, 32'h0000_0041, 4'h1, 0, rs);
      begin
        idle_cycles(5);
        tx_busy = 1'b0;
      end
    join
    chk("t2_tx_pulses", tx_cnt - tx0, 1);
    chk("t2_tx_byte", last_tx, 8'h41);
    chk("t2_b_resp", rs, 2'b00);

    // Three received bytes
    base = rx_taken;
    src_q.push_back(8'h10);
    src_q.push_back(8'h20);
    src_q.push_back(8'h30);
    idle_cycles(10);
    axi_read(A_STAT, 8'h02, 0, d, rs);
    chk("t3_status_rx", d, 32'h3);
    axi_read(A_DATA, 8'h03, 0, d, rs);
    chk("t3_byte0", d, 32'h10);
    axi_read(A_DATA, 8'h04, 0, d, rs);
    chk("t3_byte1", d, 32'h20);
    axi_read(A_DATA, 8'h05, 0, d, rs);
    chk("t3_byte2", d, 32'h30);
    axi_read(A_STAT, 8'h06, 0, d, rs);
    chk("t3_status_drained", d, 32'h1);
    chk("t3_clear_pulses", rx_taken - base, 3);

    // Fill the buffer and hold one more byte on the receiver
    base = rx_taken;
    for (int i = 0; i <= DEPTH; i++) src_q.push_back(8'h80 + 8'(i));
    idle_cycles(3 * DEPTH + 10);
    chk("fill_clear_pulses", rx_taken - base, DEPTH);
    chk("fill_byte_held", rx_ready, 1);
    axi_read(A_DATA, 8'h07, 0, d, rs);
    chk("fill_first", d, 32'h80);
    idle_cycles(3);
    chk("fill_held_pushed", rx_taken - base, DEPTH + 1);
    for (int i = 1; i <= DEPTH; i++) begin
      axi_read(A_DATA, 8'h08, 0, d, rs);
      chk("fill_order", d, 32'h80 + i);
    end
    axi_read(A_STAT, 8'h09, 0, d, rs);
    chk("fill_status_drained", d, 32'h1);

    // Unmapped offsets and no-op writes
    tx0 = tx_cnt;
    axi_read(A_BAD0, 8'h0A, 0, d, rs);
    chk("bad0_read_data", d, 32'h0);
    chk("bad0_read_resp", rs, 2'b10);
    axi_read(A_BAD4, 8'h0B, 0, d, rs);
    chk("bad4_read_resp", rs, 2'b10);
    axi_write(A_BAD0, 8'h0C, 32'h0000_0055, 4'hF, 0, rs);
    chk("bad0_write_resp", rs, 2'b10);
    axi_write(A_DATA, 8'h0D, 32'h0000_0066, 4'hE, 1, rs);
    chk("strb0_clear_resp", rs, 2'b00);
    axi_write(A_STAT, 8'h0E, 32'h0000_0077, 4'hF, 0, rs);
    chk("status_write_resp", rs, 2'b00);
    chk("noop_writes_no_tx", tx_cnt - tx0, 0);

    // Read and write requested together: the read goes first
    tx0 = tx_cnt;
    fork
      begin
        logic [31:0] rd;
        logic [1:0]  rr;
        axi_read(A_STAT, 8'h21, 3, rd, rr);
        chk("simul_read_data", rd, 32'h1);
      end
      begin
        logic [1:0] wr;
        axi_write(A_DATA, 8'h22, 32'h0000_0042, 4'h1, 2, wr);
        chk("simul_write_resp", wr, 2'b00);
      end
    join
    chk("simul_read_first", aw_hs_cyc > r_hs_cyc, 1);
    chk("simul_tx_byte", last_tx, 8'h42);
    chk("simul_tx_pulses", tx_cnt - tx0, 1);

    // Reset while waiting in W_TX
    tx0 = tx_cnt;
    tx_busy = 1'b1;
    @(posedge clk); #1;
    aw_addr = A_DATA; aw_id = 8'h77; aw_valid = 1'b1;
    @(posedge clk); #1;
    aw_valid = 1'b0; w_data = 32'h0000_0099; w_strb = 4'h1; w_valid = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0;
    idle_cycles(2);
    chk("rtx_pending_before_rst", tx_pending, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rtx_no_tx_start", tx_start, 0);
    chk("rtx_b_valid", b_valid, 0);
    chk("rtx_ar_ready", ar_ready, 1);
    chk("rtx_tx_data", tx_data, 0);
    @(posedge clk); #1;
    tx_busy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rtx_after_b_valid", b_valid, 0);
      chk("rtx_after_tx_start", tx_start, 0);
    end
    chk("rtx_tx_pulses", tx_cnt - tx0, 0);
    axi_read(A_STAT, 8'h0F, 0, d, rs);
    chk("rtx_status", d, 32'h1);

    idle_cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
